sync_pulse_gen: RTL and testbench



---
 rtl/sync_pulse_gen.sv | 158 +++++++++++++++
 tb/tb_sync_pulse_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_pulse_gen.sv
// -----------------------------------------------------------------------------
// sync_pulse_gen
//
// Programmable pulse-train generator on a single clock. A start request
// sampled while idle launches N pulses on dout, each HIGH for H clocks and
// LOW for L clocks, followed by a one-clock done strobe. Length and count
// inputs are captured when the train starts and ignored afterwards.
//
// Ports:
//   clock       system clock, all logic on the rising edge
//   rst_n       asynchronous active-low reset
//   start       request a pulse train (honoured only while idle)
//   abort       synchronous stop request, beats start, ignored when idle/FIN
//   high_len    HIGH phase length in clocks (0 behaves as 1)
//   low_len     LOW phase length in clocks (0 behaves as 1)
//   num_pulses  number of pulses in the train (0 gives an empty train)
//   dout        generated waveform, straight from a flop
//   busy        high during every HIGH and LOW clock of a train
//   done        one-clock completion strobe (also after abort / empty train)
//   pulse_idx   number of pulses started in the current/last train
// -----------------------------------------------------------------------------
module sync_pulse_gen #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [CNT_W-1:0] num_pulses,
    output logic             dout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_idx
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] phase_cnt_r;   // clocks remaining in the current phase, minus one
    logic [CNT_W-1:0] high_len_r;
    logic [CNT_W-1:0] low_len_r;
    logic [CNT_W-1:0] num_r;
    logic [CNT_W-1:0] high_eff_s;
    logic [CNT_W-1:0] low_eff_s;

    // A zero phase length would make a phase vanish; treat it as one clock.
    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b0}}) ? CNT_W'(1) : v;
    endfunction

    // Clamped phase lengths presented at the start sample.
    always_comb begin
        high_eff_s = at_least_one(high_len);
        low_eff_s  = at_least_one(low_len);
    end

    // Train sequencer with all outputs registered.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            phase_cnt_r <= {CNT_W{1'b0}};
            high_len_r  <= CNT_W'(1);
            low_len_r   <= CNT_W'(1);
            num_r       <= {CNT_W{1'b0}};
            dout        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pulse_idx   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    // abort in idle is a no-op but still masks a same-cycle start
                    if (start && !abort) begin
                        high_len_r <= high_eff_s;
                        low_len_r  <= low_eff_s;
                        num_r      <= num_pulses;
                        if (num_pulses != {CNT_W{1'b0}}) begin
                            state_r     <= ST_HIGH;
                            dout        <= 1'b1;
                            busy        <= 1'b1;
                            pulse_idx   <= CNT_W'(1);
                            phase_cnt_r <= high_eff_s - CNT_W'(1);
                        end else begin
                            // empty train: straight to the completion strobe
                            state_r   <= ST_FIN;
                            dout      <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pulse_idx <= {CNT_W{1'b0}};
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_HIGH: begin
                    if (abort) begin
                        state_r <= ST_FIN;
                        dout    <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (phase_cnt_r == {CNT_W{1'b0}}) begin
                        state_r     <= ST_LOW;
                        dout        <= 1'b0;
                        phase_cnt_r <= low_len_r - CNT_W'(1);
                    end else begin
                        phase_cnt_r <= phase_cnt_r - CNT_W'(1);
                    end
                end

                ST_LOW: begin
                    if (abort) begin
                        state_r <= ST_FIN;
                        dout    <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (phase_cnt_r == {CNT_W{1'b0}}) begin
                        // pulse_idx never exceeds num_r, so the increment cannot wrap
                        if (pulse_idx < num_r) begin
                            state_r     <= ST_HIGH;
                            dout        <= 1'b1;
                            pulse_idx   <= pulse_idx + CNT_W'(1);
                            phase_cnt_r <= high_len_r - CNT_W'(1);
                        end else begin
                            state_r <= ST_FIN;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        phase_cnt_r <= phase_cnt_r - CNT_W'(1);
                    end
                end

                ST_FIN: begin
                    // start and abort are both ignored here
                    state_r <= ST_IDLE;
                    done    <= 1'b0;
                end

                default: begin
                    state_r <= ST_IDLE;
                    dout    <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_sync_pulse_gen
//
// A per-clock reference trace of the outputs is built from the train rules
// (N pulses of H high then L low, then a done clock). The driver feeds one
// expected record per clock into a scoreboard queue; the monitor pops and
// compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_sync_pulse_gen;

    localparam int CNT_W = 8;

    logic             clock;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [CNT_W-1:0] num_pulses;
    logic             dout;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulse_idx;

    sync_pulse_gen #(.CNT_W(CNT_W)) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .high_len   (high_len),
        .low_len    (low_len),
        .num_pulses (num_pulses),
        .dout       (dout),
        .busy       (busy),
        .done       (done),
        .pulse_idx  (pulse_idx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       dout;
        logic       busy;
        logic       done;
        logic [7:0] idx;
    } rec_t;

    rec_t trace[$];   // future clocks of the train already committed
    rec_t exp_q[$];   // scoreboard: one expected record per observed clock
    rec_t cur;
    logic [7:0] last_idx;
    logic [7:0] cfg_h, cfg_l, cfg_n;

    int n_vec;
    int n_err;

    // Append the whole expected train to the trace.
    task automatic build_train(input logic [7:0] h, input logic [7:0] l, input logic [7:0] n);
        int hh;
        int ll;
        hh = (h == 8'd0) ? 1 : int'(h);
        ll = (l == 8'd0) ? 1 : int'(l);
        for (int p = 1; p <= int'(n); p++) begin
            for (int i = 0; i < hh; i++) trace.push_back('{1'b1, 1'b1, 1'b0, 8'(p)});
            for (int i = 0; i < ll; i++) trace.push_back('{1'b0, 1'b1, 1'b0, 8'(p)});
        end
        trace.push_back('{1'b0, 1'b0, 1'b1, n});
        last_idx = n;
    endtask

    // One clock: publish this clock's expectation, then set inputs for the next edge.
    task automatic step(input logic st, input logic ab, input logic rst);
        @(posedge clock);
        #1;
        if (rst) begin
            rst_n = 1'b0;
            trace.delete();
            last_idx = 8'd0;
            cur = '{1'b0, 1'b0, 1'b0, 8'd0};
        end else begin
            rst_n = 1'b1;
            if (trace.size() > 0) cur = trace.pop_front();
            else                  cur = '{1'b0, 1'b0, 1'b0, last_idx};
        end
        exp_q.push_back(cur);
        start      = st;
        abort      = ab;
        high_len   = cfg_h;
        low_len    = cfg_l;
        num_pulses = cfg_n;
        if (!rst) begin
            if (ab && cur.busy) begin
                trace.delete();
                trace.push_back('{1'b0, 1'b0, 1'b1, cur.idx});
                last_idx = cur.idx;
            end else if (st && !ab && !cur.busy && !cur.done) begin
                build_train(cfg_h, cfg_l, cfg_n);
            end
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic launch(input logic [7:0] h, input logic [7:0] l, input logic [7:0] n);
        cfg_h = h; cfg_l = l; cfg_n = n;
        step(1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: compare the DUT against the scoreboard away from the active edge.
    always @(negedge clock) begin
        rec_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (dout !== e.dout || busy !== e.busy || done !== e.done || pulse_idx !== e.idx) begin
                n_err++;
                $display("FAIL outputs @%0t: got dout=%b busy=%b done=%b idx=%0d, want dout=%b busy=%b done=%b idx=%0d",
                         $time, dout, busy, done, pulse_idx, e.dout, e.busy, e.done, e.idx);
            end
        end
    end

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_h = 8'd0; cfg_l = 8'd0; cfg_n = 8'd0;
        high_len = 8'd0; low_len = 8'd0; num_pulses = 8'd0;
        last_idx = 8'd0;

        // reset state
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        idle(3);

        // basic train H=2 L=3 N=3
        launch(8'd2, 8'd3, 8'd3);
        idle(20);

        // zero lengths and empty train
        launch(8'd0, 8'd0, 8'd2);
        idle(8);
        launch(8'd5, 8'd5, 8'd0);
        idle(4);

        // start re-pulsed mid-train with new config, held through FIN
        launch(8'd2, 8'd2, 8'd3);
        cfg_h = 8'd7; cfg_l = 8'd1; cfg_n = 8'd1;
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0);
        idle(14);

        // abort in the 2nd HIGH clock of pulse 2
        launch(8'd4, 8'd4, 8'd5);
        idle(9);
        step(1'b0, 1'b1, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 1'b0);   // abort while idle: no effect
        step(1'b1, 1'b1, 1'b0);   // abort beats start
        idle(3);

        // async reset in a LOW phase, then restart
        launch(8'd3, 8'd4, 8'd3);
        idle(5);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        idle(2);
        launch(8'd1, 8'd1, 8'd2);
        idle(8);

        // loopback-style train H=3 L=2 N=4
        launch(8'd3, 8'd2, 8'd4);
        idle(25);

        // maximum count and maximum lengths
        launch(8'd1, 8'd1, 8'd255);
        idle(515);
        launch(8'd255, 8'd255, 8'd1);
        idle(515);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cfg_h = 8'($urandom_range(0, 5));
            cfg_l = 8'($urandom_range(0, 5));
            cfg_n = 8'($urandom_range(0, 4));
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), 1'b0);
        end
        idle(60);

        @(negedge clock);
        @(negedge clock);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending records, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
